seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU, successor to the 32-bit combinational ALU. Executes
//  AND/OR/ADD/SUB/SLT in one cycle. Executes variable-amount SLL/SRL at 1 bit per cycle.
//  Executes MUL (low WIDTH bits) by shift-add, one step per cycle.
//  Sits between operand issue logic and writeback, with valid/ready on both sides.
// PARAMETERS
//  WIDTH    32  operand/result width; >=4, power of two
//  MUL_EN   1   1: MUL implemented; 0: op 3'b011 returns 0 with err=1
//  SHAMT_W  localparam = $clog2(WIDTH); shift amount = b[SHAMT_W-1:0]
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operands and op present
//  in_ready   out  1        block accepts (state IDLE)
//  oper       in   3        000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 101 SLL, 100 SRL, 011 MUL
//  a, b       in   WIDTH    operands; captured on accept
//  out_valid  out  1        result and flags valid
//  out_ready  in   1        consumer takes result
//  result     out  WIDTH    registered result
//  zero       out  1        result == 0
//  c_out      out  1        ADD/SUB carry out of MSB; 0 for other ops
//  over       out  1        ADD/SUB signed overflow; 0 for other ops
//  err        out  1        MUL requested with MUL_EN=0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1 after release.
//  - Reset values: out_valid=0, result=0, zero=0, c_out=0, over=0, err=0.
//    Reset mid-operation aborts the operation; no result is produced.
//  - Accept: in_valid && in_ready at a clock edge; a, b and oper are latched at that edge.
//  - FSM states: IDLE, EXEC, DONE.
//      IDLE --accept, 1-cycle op or shamt==0--> DONE
//      IDLE --accept, shift with shamt>0 or MUL--> EXEC (cnt = shamt or WIDTH)
//      EXEC --cnt==1 step--> DONE
//      DONE --out_ready--> IDLE
//  - Latency, accept edge to out_valid: 1 for AND/OR/ADD/SUB/SLT, shifts with shamt=0, and
//    disabled MUL; 1+shamt for SLL/SRL; 1+WIDTH for MUL.
//  - in_ready=1 only in IDLE. There is no accept in EXEC or DONE: one-cycle bubble after each
//    result handshake.
//  - DONE: out_valid=1. result and flags are held stable until out_ready. out_valid drops the
//    cycle after the handshake.
//  - SUB: a + ~b + 1. c_out=1 means no borrow.
//  - over = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is b for ADD and ~b for SUB.
//  - SLT: result = {0.., sum[MSB]^over}, using the SUB datapath. Correct across signed overflow.
//    c_out and over are reported as 0 for SLT.
//  - SLL/SRL: logical shift, zero fill. Only b[SHAMT_W-1:0] is used; upper b bits are ignored.
//  - MUL: unsigned shift-add. result = (a*b) mod 2^WIDTH; signed low half is identical.
//    Upper product bits are discarded.
//  - zero is computed from the final result for every op, including SLT/shift/MUL.
//  - Inputs are ignored while not IDLE; changing a/b/oper mid-op does not affect the result.
// STRUCTURE
//  - Package seq_alu_pkg: op encodings (OP_AND..OP_MUL), state enum {IDLE,EXEC,DONE}.
//  - Sub-module alu_addsub #(WIDTH): combinational a +/- b with c_out and over.
//    Shared by ADD/SUB/SLT and by the MUL accumulate step.
//  - Top level: FSM, step counter (SHAMT_W+1 bits), operand/accumulator registers, output regs.
// TESTING
//  1. W=32, ADD a=7FFFFFFF b=1 -> result 80000000, over=1, c_out=0, zero=0, latency 1.
//  2. SUB a=5 b=5 -> result 0, zero=1, c_out=1.
//     SLT a=80000000 b=1 -> result 1 (overflow case).
//  3. SLL a=1 b=31 -> result 80000000 after 32 cycles.
//     SRL a=F0 b=4 -> 0F after 5 cycles. SLL b=0 -> a after 1 cycle.
//  4. MUL a=FFFF b=10001 -> FFFFFFFF after 33 cycles.
//     MUL_EN=0 build: MUL -> result 0, err=1, latency 1.
//  5. Backpressure: hold out_ready=0 for 10 cycles after a result.
//     -> result stable, in_ready=0; new in_valid is ignored until the handshake.
//  6. Assert rst mid-MUL (cycle 10) -> outputs 0 immediately.
//     -> after release, in_ready=1 and the next ADD completes correctly.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings and FSM states.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_SRL = 3'b100,
    OP_SLL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_addsub.sv
// Combinational adder/subtractor with carry-out and signed overflow.
// Ports:
//   a, b   : operands
//   sub    : 1 computes a + ~b + 1, 0 computes a + b
//   sum    : WIDTH-bit result
//   c_out  : carry out of the MSB (1 = no borrow when subtracting)
//   over   : signed overflow of the operation
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             over
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    c_out = full[WIDTH];
    // Overflow: operands agree in sign but the sum does not.
    over  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, 1-bit-per-cycle shifts,
// shift-add multiply. valid/ready handshakes on both the issue and result sides.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : issue handshake (in_ready only while idle)
//   oper, a, b          : operation and operands, captured on accept
//   out_valid, out_ready: result handshake; outputs held until taken
//   result, zero        : registered result and result==0 flag
//   c_out, over         : ADD/SUB carry and signed overflow, 0 otherwise
//   err                 : MUL requested in a build without a multiplier
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             over,
  output logic             err
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned CNT_W   = SHAMT_W + 1;

  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] work;   // shift operand, or multiplicand for MUL
  logic [WIDTH-1:0] mult;   // remaining multiplier bits
  logic [WIDTH-1:0] acc;    // MUL partial product
  logic [CNT_W-1:0] cnt;

  op_e              op_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             add_sub, add_c, add_v;

  logic [WIDTH-1:0] q_res;
  logic             q_c, q_v, q_err, q_long;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] s_work, s_acc, s_res;

  // Adder is shared: issue operands while idle, accumulate step while executing.
  always_comb begin
    op_in   = op_e'(oper);
    shamt   = b[SHAMT_W-1:0];
    add_a   = a;
    add_b   = b;
    add_sub = (op_in == OP_SUB) || (op_in == OP_SLT);
    if (state == EXEC) begin
      add_a   = acc;
      add_b   = work;
      add_sub = 1'b0;
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (add_sub),
    .sum   (sum),
    .c_out (add_c),
    .over  (add_v)
  );

  // Result of an op that completes on the accept edge, or whether it needs EXEC.
  always_comb begin
    q_res    = '0;
    q_c      = 1'b0;
    q_v      = 1'b0;
    q_err    = 1'b0;
    q_long   = 1'b0;
    cnt_init = CNT_W'(shamt);
    case (op_in)
      OP_AND: q_res = a & b;
      OP_OR:  q_res = a | b;
      OP_ADD, OP_SUB: begin
        q_res = sum;
        q_c   = add_c;
        q_v   = add_v;
      end
      // Signed less-than is the true sign of a-b, i.e. sum MSB corrected by overflow.
      OP_SLT: q_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_v};
      OP_SLL, OP_SRL: begin
        q_res  = a;
        q_long = (shamt != '0);
      end
      OP_MUL: begin
        cnt_init = CNT_W'(WIDTH);
        if (MUL_EN) q_long = 1'b1;
        else        q_err  = 1'b1;
      end
      default: q_res = '0;
    endcase
  end

  // One iteration of the shift or shift-add loop.
  always_comb begin
    s_work = (op_r == OP_SRL) ? (work >> 1) : (work << 1);
    s_acc  = mult[0] ? sum : acc;
    s_res  = (op_r == OP_MUL) ? s_acc : s_work;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= OP_AND;
      work      <= '0;
      mult      <= '0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      c_out     <= 1'b0;
      over      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= op_in;
            work     <= a;
            mult     <= b;
            acc      <= '0;
            cnt      <= cnt_init;
            in_ready <= 1'b0;
            if (q_long) begin
              state <= EXEC;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= q_res;
              zero      <= (q_res == '0);
              c_out     <= q_c;
              over      <= q_v;
              err       <= q_err;
            end
          end
        end
        EXEC: begin
          work <= s_work;
          mult <= mult >> 1;
          acc  <= s_acc;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= s_res;
            zero      <= (s_res == '0);
            c_out     <= 1'b0;
            over      <= 1'b0;
            err       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: protocol/arithmetic model plus directed vectors.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  oper = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, zero, c_out, over, err;
  logic [31:0] result;

  // Second build without the multiplier.
  logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [2:0]  oper0 = 3'b000;
  logic [31:0] a0 = '0, b0 = '0;
  logic        in_ready0, out_valid0, zero0, c_out0, over0, err0;
  logic [31:0] result0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .oper(oper),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .c_out(c_out), .over(over), .err(err)
  );

  seq_alu #(.WIDTH(32), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .oper(oper0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0), .result(result0),
    .zero(zero0), .c_out(c_out0), .over(over0), .err(err0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        c;
    logic        v;
    logic [7:0]  lat;
  } exp_t;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, ls;
    logic [32:0] s33;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e = '0;
    e.lat = 8'd1;
    case (op)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b010: begin
        s33 = {1'b0, x} + {1'b0, y};
        ls  = sx + sy;
        e.res = s33[31:0];
        e.c   = s33[32];
        e.v   = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      3'b110: begin
        e.res = x - y;
        e.c   = (x >= y);
        ls    = sx - sy;
        e.v   = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      3'b111: e.res = (sx < sy) ? 32'd1 : 32'd0;
      3'b101: begin
        e.res = x << y[4:0];
        e.lat = 8'd1 + 8'(y[4:0]);
      end
      3'b100: begin
        e.res = x >> y[4:0];
        e.lat = 8'd1 + 8'(y[4:0]);
      end
      default: begin
        p     = {32'b0, x} * {32'b0, y};
        e.res = p[31:0];
        e.lat = 8'd33;
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  exp_t nx;
  exp_t m = '0;
  logic pending = 1'b0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always_comb nx = model(oper, a, b);

  // Protocol model: accept when idle, release on handshake once the result is due.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      if (!pending && in_valid) begin
        m       <= nx;
        pending <= 1'b1;
        acc_cyc <= cyc + 1;
      end else if (pending && out_ready && (cyc >= acc_cyc + int'(m.lat) - 1)) begin
        pending <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  function automatic logic due();
    return pending && (cyc >= acc_cyc + int'(m.lat) - 1);
  endfunction

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(due()));
      chk("in_ready", 64'(in_ready), 64'(!pending));
      if (due()) begin
        chk("result", 64'(result), 64'(m.res));
        chk("zero", 64'(zero), 64'(m.zero));
        chk("c_out", 64'(c_out), 64'(m.c));
        chk("over", 64'(over), 64'(m.v));
        chk("err", 64'(err), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    oper = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    oper = 3'($urandom);
  endtask

  task automatic finish_op(input string nm, input logic [31:0] lit, input logic [2:0] lit_f,
                           input int lit_lat, input int hold);
    chk({nm, " model_lat"}, 64'(m.lat), 64'(lit_lat));
    chk({nm, " model_res"}, 64'(m.res), 64'(lit));
    @(negedge clk);
    while (!due()) @(negedge clk);
    chk({nm, " result"}, 64'(result), 64'(lit));
    chk({nm, " flags"}, 64'({zero, c_out, over}), 64'(lit_f));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      oper = 3'b010;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string nm, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] lit, input logic [2:0] lit_f, input int lit_lat);
    issue(op, x, y);
    finish_op(nm, lit, lit_f, lit_lat, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset result", 64'(result), 64'd0);
    chk("reset flags", 64'({out_valid, zero, c_out, over, err}), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);

    // Build without multiplier: MUL finishes at once with err and a zero result.
    in_valid0 = 1'b1;
    oper0 = 3'b011;
    a0 = 32'h1234;
    b0 = 32'h5678;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("nomul out_valid", 64'(out_valid0), 64'd1);
    chk("nomul result", 64'(result0), 64'd0);
    chk("nomul err", 64'(err0), 64'd1);
    chk("nomul zero", 64'(zero0), 64'd1);
    chk("nomul in_ready", 64'(in_ready0), 64'd0);
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    chk("nomul drop", 64'(out_valid0), 64'd0);

    run("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b001, 1);
    run("add_carry", 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b110, 1);
    run("sub_eq", 3'b110, 32'h5, 32'h5, 32'h0, 3'b110, 1);
    run("sub_borrow", 3'b110, 32'h3, 32'h5, 32'hFFFF_FFFE, 3'b000, 1);
    run("slt_ovf", 3'b111, 32'h8000_0000, 32'h1, 32'h1, 3'b000, 1);
    run("slt_ovf2", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 3'b100, 1);
    run("and", 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 3'b000, 1);
    run("or", 3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 3'b000, 1);
    run("sll31", 3'b101, 32'h1, 32'd31, 32'h8000_0000, 3'b000, 32);
    run("srl4", 3'b100, 32'hF0, 32'd4, 32'h0F, 3'b000, 5);
    run("sll0", 3'b101, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 3'b000, 1);
    run("srl_hi_b", 3'b100, 32'h8000_0000, 32'h23, 32'h1000_0000, 3'b000, 4);
    run("mul_a", 3'b011, 32'hFFFF, 32'h1_0001, 32'hFFFF_FFFF, 3'b000, 33);
    run("mul_b", 3'b011, 32'h1234_5678, 32'h10, 32'h2345_6780, 3'b000, 33);
    run("mul_neg", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 3'b000, 33);
    run("mul_zero", 3'b011, 32'h0, 32'h5, 32'h0, 3'b100, 33);

    // Backpressure: result held while the consumer stalls and new requests are offered.
    issue(3'b010, 32'h1, 32'h2);
    finish_op("backpressure", 32'h3, 3'b000, 1, 10);

    // Reset in the middle of a multiply.
    issue(3'b011, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid result", 64'(result), 64'd0);
    chk("rst_mid outs", 64'({out_valid, zero, c_out, over, err}), 64'd0);
    chk("rst_mid in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("add_after_rst", 3'b010, 32'h2, 32'h3, 32'h5, 3'b000, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
